// File: rtl/nn_infer_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : nn_infer_sequencer_pkg
//  Brief   : Shared state encoding, default sizes and width helper for the
//            inference sequencer and its byte serialiser.
//  Rev     : 1.0  initial release
// ============================================================================
package nn_infer_sequencer_pkg;

  localparam int DEF_IN_BYTES    = 256;
  localparam int DEF_OUT_BYTES   = 10;
  localparam int DEF_NUM_STAGES  = 9;
  localparam int DEF_TIMEOUT_CYC = 1_000_000;

  // One-hot sequencer states
  typedef enum logic [5:0] {
    ST_RECV  = 6'b000001,
    ST_RUN   = 6'b000010,
    ST_WAIT  = 6'b000100,
    ST_LATCH = 6'b001000,
    ST_SEND  = 6'b010000,
    ST_ERR   = 6'b100000
  } state_t;

  // Counter/index width for n items, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nn_byte_serializer.sv
`default_nettype none
// ============================================================================
//  Module  : nn_byte_serializer
//  Brief   : Captures a result frame and streams it out one byte per
//            valid/ready handshake, lowest byte first.
//  Rev     : 1.0  initial release
// ============================================================================
module nn_byte_serializer
  import nn_infer_sequencer_pkg::*;
#(
  parameter int OUT_BYTES = DEF_OUT_BYTES
) (
  input  logic                   clk_100MHz,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic                   flush_i,
  input  logic [OUT_BYTES*8-1:0] frame_i,
  output logic                   tx_valid_o,
  output logic [7:0]             tx_data_o,
  input  logic                   tx_ready_i,
  output logic                   last_o
);

  localparam int             CW      = idx_width(OUT_BYTES);
  localparam logic [CW-1:0]  TX_LAST = CW'(OUT_BYTES - 1);

  logic [OUT_BYTES*8-1:0] out_buf_q;
  logic [CW-1:0]          tx_cnt_q;
  logic                   valid_q;
  logic                   tx_fire;

  assign tx_fire    = valid_q && tx_ready_i;
  assign last_o     = tx_fire && (tx_cnt_q == TX_LAST);
  assign tx_valid_o = valid_q;
  // Data is forced to zero whenever no byte is on offer
  assign tx_data_o  = valid_q ? out_buf_q[{tx_cnt_q, 3'b000} +: 8] : 8'h00;

  // Frame capture, byte pointer and valid flag; flush wins over everything
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      out_buf_q <= '0;
      tx_cnt_q  <= '0;
      valid_q   <= 1'b0;
    end else if (flush_i) begin
      tx_cnt_q  <= '0;
      valid_q   <= 1'b0;
    end else if (load_i) begin
      out_buf_q <= frame_i;
      tx_cnt_q  <= '0;
      valid_q   <= 1'b1;
    end else if (tx_fire) begin
      if (tx_cnt_q == TX_LAST) begin
        tx_cnt_q <= '0;
        valid_q  <= 1'b0;
      end else begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/nn_infer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : nn_infer_sequencer
//  Brief   : Receives an input frame byte-wise, starts the compute stages in
//            order with a done timeout, then serialises the result frame.
//  Rev     : 1.0  initial release
// ============================================================================
module nn_infer_sequencer
  import nn_infer_sequencer_pkg::*;
#(
  parameter int IN_BYTES    = DEF_IN_BYTES,
  parameter int OUT_BYTES   = DEF_OUT_BYTES,
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                   clk_100MHz,
  input  logic                   rst_n,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  output logic                   rx_ready,
  output logic [IN_BYTES*8-1:0]  in_buf,
  output logic [NUM_STAGES-1:0]  stage_start,
  input  logic [NUM_STAGES-1:0]  stage_done,
  input  logic [OUT_BYTES*8-1:0] result,
  output logic                   tx_valid,
  output logic [7:0]             tx_data,
  input  logic                   tx_ready,
  input  logic                   abort,
  output logic                   busy,
  output logic                   err_timeout,
  output logic [15:0]            frame_cnt
);

  localparam int            RW       = idx_width(IN_BYTES);
  localparam int            SW       = idx_width(NUM_STAGES);
  localparam int            TW       = idx_width(TIMEOUT_CYC);
  localparam logic [RW-1:0] RX_LAST  = RW'(IN_BYTES - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(NUM_STAGES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t                  state_q;
  logic [RW-1:0]           rx_cnt_q;
  logic [SW-1:0]           s_q;
  logic [TW-1:0]           tmo_q;
  logic [IN_BYTES*8-1:0]   in_buf_q;
  logic                    rx_ready_q;
  logic [NUM_STAGES-1:0]   stage_start_q;
  logic                    err_q;
  logic [15:0]             frame_cnt_q;
  logic                    rx_fire;
  logic                    ser_load;
  logic                    ser_last;

  assign rx_fire  = rx_valid && rx_ready_q && (state_q == ST_RECV);
  assign ser_load = (state_q == ST_LATCH);

  // Sequencer: receive, per-stage start/wait with timeout, latch, send, error
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RECV;
      rx_cnt_q      <= '0;
      s_q           <= '0;
      tmo_q         <= '0;
      in_buf_q      <= '0;
      rx_ready_q    <= 1'b0;
      stage_start_q <= '0;
      err_q         <= 1'b0;
      frame_cnt_q   <= '0;
    end else if (abort) begin
      // Frame data and frame count survive an abort; everything else restarts
      state_q       <= ST_RECV;
      rx_cnt_q      <= '0;
      s_q           <= '0;
      tmo_q         <= '0;
      rx_ready_q    <= 1'b1;
      stage_start_q <= '0;
      err_q         <= 1'b0;
    end else begin
      stage_start_q <= '0;
      case (state_q)
        ST_RECV: begin
          rx_ready_q <= 1'b1;
          if (rx_fire) begin
            in_buf_q[{rx_cnt_q, 3'b000} +: 8] <= rx_data;
            if (rx_cnt_q == RX_LAST) begin
              rx_cnt_q   <= '0;
              rx_ready_q <= 1'b0;
              s_q        <= '0;
              state_q    <= ST_RUN;
            end else begin
              rx_cnt_q <= rx_cnt_q + 1'b1;
            end
          end
        end
        ST_RUN: begin
          stage_start_q <= NUM_STAGES'(1) << s_q;
          tmo_q         <= '0;
          state_q       <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done arriving on the final timeout clock still counts as done
          if (stage_done[s_q]) begin
            if (s_q == S_LAST) begin
              state_q <= ST_LATCH;
            end else begin
              s_q     <= s_q + 1'b1;
              state_q <= ST_RUN;
            end
          end else if (tmo_q == TMO_LAST) begin
            err_q   <= 1'b1;
            state_q <= ST_ERR;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        ST_LATCH: state_q <= ST_SEND;
        ST_SEND: begin
          if (ser_last) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
            rx_ready_q  <= 1'b1;
            state_q     <= ST_RECV;
          end
        end
        ST_ERR: begin
          // Parked with handshakes idle until abort
        end
        default: state_q <= ST_RECV;
      endcase
    end
  end

  nn_byte_serializer #(
    .OUT_BYTES (OUT_BYTES)
  ) u_ser (
    .clk_100MHz (clk_100MHz),
    .rst_n      (rst_n),
    .load_i     (ser_load),
    .flush_i    (abort),
    .frame_i    (result),
    .tx_valid_o (tx_valid),
    .tx_data_o  (tx_data),
    .tx_ready_i (tx_ready),
    .last_o     (ser_last)
  );

  assign rx_ready    = rx_ready_q;
  assign in_buf      = in_buf_q;
  assign stage_start = stage_start_q;
  assign err_timeout = err_q;
  assign frame_cnt   = frame_cnt_q;
  assign busy        = (state_q != ST_RECV) || (rx_cnt_q != '0);

endmodule
`default_nettype wire

// File: tb/tb_nn_infer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module  : tb_nn_infer_sequencer
//  Brief   : Directed self-checking bench for nn_infer_sequencer: full frame,
//            tx back-pressure, stage timeout, abort, reset in SEND and a
//            minimal-size configuration.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_nn_infer_sequencer;

  localparam int NB  = 256;
  localparam int NO  = 10;
  localparam int NS  = 9;
  localparam int TMO = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  // Instance A: full-size frame, short timeout
  logic            rx_valid_a = 1'b0;
  logic [7:0]      rx_data_a  = 8'h00;
  logic            rx_ready_a;
  logic [NB*8-1:0] in_buf_a;
  logic [NS-1:0]   stage_start_a;
  logic [NS-1:0]   stage_done_a = '0;
  logic [NO*8-1:0] result_a = '0;
  logic            tx_valid_a;
  logic [7:0]      tx_data_a;
  logic            tx_ready_a = 1'b0;
  logic            abort_a    = 1'b0;
  logic            busy_a;
  logic            err_a;
  logic [15:0]     frame_cnt_a;
  // Instance B: 4-byte frame, 1 result byte, single stage
  logic            rx_valid_b = 1'b0;
  logic [7:0]      rx_data_b  = 8'h00;
  logic            rx_ready_b;
  logic [31:0]     in_buf_b;
  logic [0:0]      stage_start_b;
  logic [0:0]      stage_done_b = 1'b1;
  logic [7:0]      result_b = 8'hC3;
  logic            tx_valid_b;
  logic [7:0]      tx_data_b;
  logic            tx_ready_b = 1'b0;
  logic            abort_b    = 1'b0;
  logic            busy_b;
  logic            err_b;
  logic [15:0]     frame_cnt_b;

  nn_infer_sequencer #(
    .IN_BYTES(NB), .OUT_BYTES(NO), .NUM_STAGES(NS), .TIMEOUT_CYC(TMO)
  ) dut_a (
    .clk_100MHz(clk), .rst_n(rst_n),
    .rx_valid(rx_valid_a), .rx_data(rx_data_a), .rx_ready(rx_ready_a),
    .in_buf(in_buf_a), .stage_start(stage_start_a), .stage_done(stage_done_a),
    .result(result_a), .tx_valid(tx_valid_a), .tx_data(tx_data_a),
    .tx_ready(tx_ready_a), .abort(abort_a), .busy(busy_a),
    .err_timeout(err_a), .frame_cnt(frame_cnt_a)
  );

  nn_infer_sequencer #(
    .IN_BYTES(4), .OUT_BYTES(1), .NUM_STAGES(1), .TIMEOUT_CYC(TMO)
  ) dut_b (
    .clk_100MHz(clk), .rst_n(rst_n),
    .rx_valid(rx_valid_b), .rx_data(rx_data_b), .rx_ready(rx_ready_b),
    .in_buf(in_buf_b), .stage_start(stage_start_b), .stage_done(stage_done_b),
    .result(result_b), .tx_valid(tx_valid_b), .tx_data(tx_data_b),
    .tx_ready(tx_ready_b), .abort(abort_b), .busy(busy_b),
    .err_timeout(err_b), .frame_cnt(frame_cnt_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_res(input int k);
    return 8'(8'h40 + 7 * k);
  endfunction

  // Stage responder: done rises 5 clocks after its start, unless hung
  int            st_cnt [NS];
  logic [NS-1:0] hang = '0;
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NS; i++) begin
      if (!rst_n) begin
        st_cnt[i]       = 0;
        stage_done_a[i] = 1'b0;
      end else if (stage_start_a[i]) begin
        st_cnt[i]       = 5;
        stage_done_a[i] = 1'b0;
      end else if (st_cnt[i] > 0) begin
        st_cnt[i]--;
        if (st_cnt[i] == 0 && !hang[i]) stage_done_a[i] = 1'b1;
      end
    end
  end

  // Recorders: stage start order/shape and accepted tx bytes
  int            start_q[$];
  int            start_bad = 0;
  logic [NS-1:0] prev_start = '0;
  logic [7:0]    tx_q_a[$];
  logic [7:0]    tx_q_b[$];
  always @(negedge clk) begin
    if (stage_start_a != '0) begin
      if (!$onehot(stage_start_a) || prev_start != '0) start_bad++;
      for (int i = 0; i < NS; i++) if (stage_start_a[i]) start_q.push_back(i);
    end
    prev_start = stage_start_a;
    if (tx_valid_a && tx_ready_a) tx_q_a.push_back(tx_data_a);
    if (tx_valid_b && tx_ready_b) tx_q_b.push_back(tx_data_b);
  end

  function automatic int inbuf_miss(input logic [7:0] x);
    int m = 0;
    for (int k = 0; k < NB; k++) if (in_buf_a[k*8 +: 8] !== (8'(k) ^ x)) m++;
    return m;
  endfunction

  function automatic int tx_miss();
    int m = 0;
    for (int k = 0; k < NO; k++)
      if (k >= tx_q_a.size() || tx_q_a[k] !== exp_res(k)) m++;
    return m;
  endfunction

  function automatic int start_miss(input int n);
    int m = 0;
    for (int k = 0; k < n; k++)
      if (k >= start_q.size() || start_q[k] != k) m++;
    return m;
  endfunction

  task automatic send_bytes(input bit to_b, input int n, input logic [7:0] x);
    int   sent = 0;
    int   g    = 0;
    logic acc;
    while (sent < n && g < 4 * n + 20) begin
      if (to_b) begin
        rx_valid_b = 1'b1; rx_data_b = 8'(sent) ^ x; acc = rx_ready_b;
      end else begin
        rx_valid_a = 1'b1; rx_data_a = 8'(sent) ^ x; acc = rx_ready_a;
      end
      tick();
      g++;
      if (acc) sent++;
    end
    rx_valid_a = 1'b0;
    rx_valid_b = 1'b0;
    check(to_b ? "b_rx_sent" : "a_rx_sent", 64'(sent), 64'(n));
  endtask

  initial begin
    int         g;
    int         cnt;
    logic [7:0] hold;

    for (int k = 0; k < NO; k++) result_a[k*8 +: 8] = exp_res(k);

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    #12;
    check("rst_rx_ready", rx_ready_a, 0);
    check("rst_tx_valid", tx_valid_a, 0);
    check("rst_tx_data", tx_data_a, 0);
    check("rst_stage_start", stage_start_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_err", err_a, 0);
    check("rst_frame_cnt", frame_cnt_a, 0);
    #1 rst_n = 1'b1;
    #1;
    check("rel_rx_ready_low", rx_ready_a, 0);
    tick();
    check("rel_rx_ready_high", rx_ready_a, 1);

    // ---------------- minimal configuration (B) ----------------
    send_bytes(1'b1, 4, 8'h10);
    check("b_in_buf", in_buf_b, 32'h13121110);
    g = 0;
    while (stage_start_b !== 1'b1 && g < 50) begin tick(); g++; end
    check("b_start_seen", stage_start_b, 1);
    cnt = 0;
    while (!tx_valid_b && cnt < 50) begin tick(); cnt++; end
    check("b_start_to_txv_le4", (cnt <= 4), 1);
    check("b_tx_data", tx_data_b, 8'hC3);
    tx_ready_b = 1'b1;
    tick();
    tx_ready_b = 1'b0;
    check("b_tx_count", tx_q_b.size(), 1);
    check("b_tx_valid_drop", tx_valid_b, 0);
    check("b_frame_cnt", frame_cnt_b, 1);

    // ---------------- frame 1 with back-pressure ----------------
    send_bytes(1'b0, NB, 8'h00);
    check("f1_rx_ready_low", rx_ready_a, 0);
    check("f1_busy", busy_a, 1);
    check("f1_in_buf_miss", inbuf_miss(8'h00), 0);
    g = 0;
    while (!tx_valid_a && g < 1000) begin tick(); g++; end
    check("f1_tx_valid", tx_valid_a, 1);
    check("f1_start_count", start_q.size(), NS);
    check("f1_start_order_miss", start_miss(NS), 0);
    check("f1_start_shape_bad", start_bad, 0);
    check("f1_first_byte", tx_data_a, exp_res(0));
    tx_ready_a = 1'b1;
    tick(4);
    tx_ready_a = 1'b0;
    hold = tx_data_a;
    check("f1_hold_byte4", hold, exp_res(4));
    for (int i = 0; i < 7; i++) begin
      tick();
      check("f1_stall_stable", {tx_valid_a, tx_data_a}, {1'b1, hold});
    end
    check("f1_stall_count", tx_q_a.size(), 4);
    tx_ready_a = 1'b1;
    g = 0;
    while (tx_q_a.size() < NO && g < 200) begin tick(); g++; end
    check("f1_tx_count", tx_q_a.size(), NO);
    check("f1_tx_miss", tx_miss(), 0);
    check("f1_tx_valid_drop", tx_valid_a, 0);
    check("f1_frame_cnt", frame_cnt_a, 1);
    tick();
    check("f1_idle_rx_ready", rx_ready_a, 1);
    check("f1_idle_busy", busy_a, 0);

    // ---------------- abort after 100 bytes, then full frame ----------------
    start_q.delete();
    tx_q_a.delete();
    send_bytes(1'b0, 100, 8'hFF);
    check("ab_busy_before", busy_a, 1);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    check("ab_busy", busy_a, 0);
    check("ab_rx_ready", rx_ready_a, 1);
    check("ab_frame_cnt", frame_cnt_a, 1);
    check("ab_keep_slot0", in_buf_a[0 +: 8], 8'hFF);
    check("ab_keep_slot150", in_buf_a[150*8 +: 8], 8'd150);
    send_bytes(1'b0, NB, 8'hA5);
    check("ab_in_buf_miss", inbuf_miss(8'hA5), 0);
    g = 0;
    while (frame_cnt_a != 16'd2 && g < 1000) begin tick(); g++; end
    check("ab_frame_cnt2", frame_cnt_a, 2);
    check("ab_tx_miss", tx_miss(), 0);
    check("ab_start_order_miss", start_miss(NS), 0);

    // ---------------- stage 3 timeout ----------------
    start_q.delete();
    tx_q_a.delete();
    hang[3] = 1'b1;
    send_bytes(1'b0, NB, 8'h00);
    g = 0;
    while (stage_start_a[3] !== 1'b1 && g < 300) begin tick(); g++; end
    check("to_start3_seen", stage_start_a[3], 1);
    cnt = 0;
    while (!err_a && cnt < 300) begin tick(); cnt++; end
    check("to_err_clock", cnt, TMO);
    tick(20);
    check("to_err_held", err_a, 1);
    check("to_no_more_starts", start_q.size(), 4);
    check("to_handshakes_low", {rx_ready_a, tx_valid_a, stage_start_a}, 0);
    check("to_busy", busy_a, 1);
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    hang[3] = 1'b0;
    check("to_abort_err", err_a, 0);
    check("to_abort_rx_ready", rx_ready_a, 1);
    check("to_abort_busy", busy_a, 0);
    check("to_abort_frame_cnt", frame_cnt_a, 2);

    // ---------------- reset during SEND byte 4 ----------------
    tx_q_a.delete();
    send_bytes(1'b0, NB, 8'h3C);
    g = 0;
    while (!tx_valid_a && g < 1000) begin tick(); g++; end
    check("rs_tx_valid", tx_valid_a, 1);
    tx_ready_a = 1'b1;
    tick(4);
    tx_ready_a = 1'b0;
    check("rs_byte4", tx_data_a, exp_res(4));
    #2 rst_n = 1'b0;
    #1;
    check("rs_outputs_zero",
          {rx_ready_a, tx_valid_a, tx_data_a, stage_start_a, busy_a, err_a}, 0);
    check("rs_frame_cnt", frame_cnt_a, 0);
    check("rs_in_buf_cleared", inbuf_miss(8'h00), NB - 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    check("rs_rel_rx_ready_low", rx_ready_a, 0);
    tick();
    check("rs_rel_rx_ready_high", rx_ready_a, 1);
    tx_ready_a = 1'b1;
    tick(5);
    check("rs_no_tx", {tx_valid_a, 32'(tx_q_a.size())}, {1'b0, 32'd4});
    check("rs_busy_idle", busy_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
